// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin
// arbitration, a one-entry registered result buffer per port, and the
// architectural condition-code register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_vld_n / req_rdy_n    request handshake (rdy is the grant)
//   req_a_n, req_b_n         signed operands
//   req_fn_n                 00 add, 01 sub, 10 and, 11 xor
//   req_set_cc_n             latch this op's flags into cc
//   rsp_vld_n / rsp_rdy_n    result handshake
//   rsp_out_n, rsp_cf_n      registered result and flags {ZF,SF,OF}
//   cc                       condition-code register {ZF,SF,OF}

// Combinational ALU. Flags are {ZF, SF, OF}; OF only for add/sub.
module alu #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   fn_i,
  output logic [W-1:0] out_o,
  output logic [2:0]   cf_o
);
  logic of;

  always_comb begin
    out_o = '0;
    of    = 1'b0;
    unique case (fn_i)
      2'b00: begin
        out_o = a_i + b_i;
        // Operands share a sign and the result sign differs.
        of    = (a_i[W-1] == b_i[W-1]) && (out_o[W-1] != a_i[W-1]);
      end
      2'b01: begin
        out_o = a_i - b_i;
        // Operands differ in sign and the result takes b's sign.
        of    = (a_i[W-1] != b_i[W-1]) && (out_o[W-1] != a_i[W-1]);
      end
      2'b10:   out_o = a_i & b_i;
      default: out_o = a_i ^ b_i;
    endcase
    cf_o = {(out_o == '0), out_o[W-1], of};
  end
endmodule

// One-entry result buffer. A load in the same cycle as a drain wins,
// so the buffer stays full with the new result.
module alu_arbiter_rsp_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] out_d_i,
  input  logic [2:0]   cf_d_i,
  output logic         vld_o,
  output logic [W-1:0] out_o,
  output logic [2:0]   cf_o
);
  logic         vld_q, vld_d;
  logic [W-1:0] out_q, out_d;
  logic [2:0]   cf_q,  cf_d;

  always_comb begin
    vld_d = vld_q;
    out_d = out_q;
    cf_d  = cf_q;
    if (load_i) begin
      vld_d = 1'b1;
      out_d = out_d_i;
      cf_d  = cf_d_i;
    end else if (drain_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      out_q <= '0;
      cf_q  <= '0;
    end else begin
      vld_q <= vld_d;
      out_q <= out_d;
      cf_q  <= cf_d;
    end
  end

  assign vld_o = vld_q;
  assign out_o = out_q;
  assign cf_o  = cf_q;
endmodule

module alu_arbiter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_vld_0,
  input  logic         req_vld_1,
  output logic         req_rdy_0,
  output logic         req_rdy_1,
  input  logic [W-1:0] req_a_0,
  input  logic [W-1:0] req_a_1,
  input  logic [W-1:0] req_b_0,
  input  logic [W-1:0] req_b_1,
  input  logic [1:0]   req_fn_0,
  input  logic [1:0]   req_fn_1,
  input  logic         req_set_cc_0,
  input  logic         req_set_cc_1,
  output logic         rsp_vld_0,
  output logic         rsp_vld_1,
  input  logic         rsp_rdy_0,
  input  logic         rsp_rdy_1,
  output logic [W-1:0] rsp_out_0,
  output logic [W-1:0] rsp_out_1,
  output logic [2:0]   rsp_cf_0,
  output logic [2:0]   rsp_cf_1,
  output logic [2:0]   cc
);
  localparam int NP = 2;

  logic [NP-1:0]        req_vld, req_set_cc, rsp_rdy, rsp_vld, elig, gnt;
  logic [NP-1:0][W-1:0] req_a, req_b, rsp_out;
  logic [NP-1:0][1:0]   req_fn;
  logic [NP-1:0][2:0]   rsp_cf;

  logic         ptr_q, ptr_d;
  logic [2:0]   cc_q, cc_d;
  logic         sel;
  logic [W-1:0] alu_out;
  logic [2:0]   alu_cf;

  assign req_vld    = {req_vld_1, req_vld_0};
  assign req_set_cc = {req_set_cc_1, req_set_cc_0};
  assign rsp_rdy    = {rsp_rdy_1, rsp_rdy_0};
  assign req_a      = {req_a_1, req_a_0};
  assign req_b      = {req_b_1, req_b_0};
  assign req_fn     = {req_fn_1, req_fn_0};

  // A full buffer that drains this cycle can take a new result.
  assign elig = req_vld & (~rsp_vld | rsp_rdy);

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (&elig) gnt[ptr_q] = 1'b1;
      else       gnt        = elig;
    end
  end

  assign req_rdy_0 = gnt[0];
  assign req_rdy_1 = gnt[1];

  // Port 0 drives the ALU whenever port 1 is not granted.
  assign sel = gnt[1];

  alu #(.W(W)) u_alu (
    .a_i   (req_a[sel]),
    .b_i   (req_b[sel]),
    .fn_i  (req_fn[sel]),
    .out_o (alu_out),
    .cf_o  (alu_cf)
  );

  always_comb begin
    ptr_d = ptr_q;
    cc_d  = cc_q;
    if (|gnt) begin
      ptr_d = ~sel;
      if (req_set_cc[sel]) cc_d = alu_cf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      cc_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      cc_q  <= cc_d;
    end
  end

  for (genvar n = 0; n < NP; n++) begin : g_buf
    alu_arbiter_rsp_buf #(.W(W)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (gnt[n]),
      .drain_i (rsp_vld[n] & rsp_rdy[n]),
      .out_d_i (alu_out),
      .cf_d_i  (alu_cf),
      .vld_o   (rsp_vld[n]),
      .out_o   (rsp_out[n]),
      .cf_o    (rsp_cf[n])
    );
  end

  assign rsp_vld_0 = rsp_vld[0];
  assign rsp_vld_1 = rsp_vld[1];
  assign rsp_out_0 = rsp_out[0];
  assign rsp_out_1 = rsp_out[1];
  assign rsp_cf_0  = rsp_cf[0];
  assign rsp_cf_1  = rsp_cf[1];
  assign cc        = cc_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single Execute-stage `alu` instance between two requesters: port 0 is the Execute datapath and port 1 is the address/auxiliary path. Arbitration is round-robin with a valid/ready handshake on each request port. Each port has a one-entry registered result buffer with its own valid/ready handshake. The block also owns the architectural condition-code register (CC) and updates it only from operations flagged `set_cc`.

## Interface
Parameters:
- `W`, 64, operand/result width (must match `alu`)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_vld_0`, `req_vld_1`  in  1  request valid per port
- `req_rdy_0`, `req_rdy_1`  out  1  grant; a request transfers when `req_vld_n & req_rdy_n`
- `req_a_0`, `req_a_1`  in  W  operand a (signed)
- `req_b_0`, `req_b_1`  in  W  operand b (signed)
- `req_fn_0`, `req_fn_1`  in  2  ALU control: 00 add (a+b), 01 sub (a−b), 10 and, 11 xor
- `req_set_cc_0`, `req_set_cc_1`  in  1  latch this op's flags into CC
- `rsp_vld_0`, `rsp_vld_1`  out  1  result buffer full
- `rsp_rdy_0`, `rsp_rdy_1`  in  1  consumer accepts result
- `rsp_out_0`, `rsp_out_1`  out  W  registered ALU result
- `rsp_cf_0`, `rsp_cf_1`  out  3  registered flags: [2]=ZF, [1]=SF, [0]=OF
- `cc`  out  3  condition-code register, same bit order as `rsp_cf`

## Operation
- Instantiates exactly one `alu`. Its a/b/control inputs are muxed from the granted port, or from port 0 when no port is granted.
- Port n is eligible when `req_vld_n` is high and its result buffer is free. Free means `!rsp_vld_n`, or `rsp_vld_n & rsp_rdy_n` in the same cycle (drain and refill in one cycle is allowed).
- Round-robin pointer `ptr`, 1 bit:
  - Both ports eligible: grant port `ptr`.
  - One port eligible: grant that port.
  - None eligible: no grant.
- At most one of `req_rdy_0` / `req_rdy_1` is high in any cycle. `req_rdy_n` is combinational from the current-cycle inputs and state.
- On a grant to port k: `ptr <= ~k`. With no grant, `ptr` holds.
- Grant edge updates:
  - `rsp_out_k <= alu.out`, `rsp_cf_k <= alu.cf`, `rsp_vld_k <= 1`.
  - If `req_set_cc_k`, then `cc <= alu.cf`.
- Result buffer clears (`rsp_vld_n <= 0`) on `rsp_vld_n & rsp_rdy_n` unless refilled in the same cycle.
- `rsp_out_n` and `rsp_cf_n` hold their value while `rsp_vld_n` is high. When the buffer is empty they keep their last value; this is don't-care for consumers.
- Arithmetic is W-bit two's complement and wraps. Overflow is reported only via OF and never saturates.
- Requesters must hold `req_*` stable while `req_vld_n` is high and `req_rdy_n` is low. A requester may deassert valid only after the transfer.
- Per-port state: EMPTY → FULL on grant. FULL → EMPTY on drain without refill. FULL → FULL on drain with refill (new data).

## Timing
- Latency: request accepted in cycle T produces its result with `rsp_vld` high from cycle T+1.
- CC reflects a `set_cc` op from cycle T+1.
- Throughput: one op per cycle in aggregate. With both ports saturated and responses drained every cycle, grants alternate 0,1,0,1.
- A port whose buffer is full and not draining is skipped. The other port may take consecutive grants; `ptr` still toggles per grant.
- Reset: while `rst` is high, `req_rdy_*` = 0 (forced combinationally). At the edge, all `rsp_vld_*`, `rsp_out_*`, `rsp_cf_*`, `cc` and `ptr` are cleared to 0.
- Reset mid-operation discards any pending result and does not update CC.
- The first grant after `rst` falls: if both ports are valid, port 0 wins.
- Simultaneous grant and drain on the same port in one cycle: the new result replaces the old one and `rsp_vld` stays 1.

## Test plan
- Single op: port 0, a=11, b=4, fn=00, set_cc=1 → `req_rdy_0` same cycle; T+1 `rsp_out_0`=15, `rsp_cf_0`=000, `cc`=000.
- Flags into CC only when flagged:
  - Port 1 sub, a=4, b=4, set_cc=0 → `rsp_cf_1`=100, `cc` unchanged.
  - Repeat with set_cc=1 → `cc`=100.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, fn=00 → out=0x8000_0000_0000_0000, cf=011. Also a=−11, b=4, fn=01 → out=−15, cf=010.
- Contention: both ports valid every cycle, `rsp_rdy` tied high → grant sequence 0,1,0,1. Each port gets one `rsp_vld` pulse per two cycles with the correct per-port results.
- Backpressure:
  - Hold `rsp_rdy_0`=0 after one port-0 result → `req_rdy_0` stays 0, port 1 is granted every cycle, `rsp_out_0` is stable.
  - Raise `rsp_rdy_0` with `req_vld_0` high → drain and refill in the same cycle, `rsp_vld_0` stays 1 with the new value.
- Reset mid-flight: grant in cycle T, assert `rst` in cycle T+1 → next cycle all `rsp_vld`=0, `cc`=000, `ptr`=0, and no `req_rdy` while `rst` is high.
